// File: rtl/fmc_adc_pattern_gen_if.sv
// Control/data bundle between the FMC-ADC core and the test-pattern generator.
// The master side drives configuration and strobes; the slave side is the generator.
interface fmc_adc_pattern_gen_if #(
    parameter int g_NB_CHANNELS = 4,
    parameter int g_DATA_WIDTH  = 16
);
    logic                                   enable;
    logic                                   sync;
    logic                                   sample_en;
    logic [1:0]                             mode;
    logic [g_DATA_WIDTH-1:0]                step;
    logic [g_DATA_WIDTH-1:0]                lower;
    logic [g_DATA_WIDTH-1:0]                upper;
    logic [g_NB_CHANNELS-1:0]               invert;
    logic [g_NB_CHANNELS*g_DATA_WIDTH-1:0]  data;
    logic                                   valid;
    logic                                   running;
    logic                                   cfg_err;
    logic [31:0]                            sample_cnt;

    modport master (
        output enable, sync, sample_en, mode, step, lower, upper, invert,
        input  data, valid, running, cfg_err, sample_cnt
    );

    modport slave (
        input  enable, sync, sample_en, mode, step, lower, upper, invert,
        output data, valid, running, cfg_err, sample_cnt
    );
endinterface

// File: rtl/fmc_adc_pattern_gen.sv
// Multi-channel ADC test-pattern generator (zero / triangle / sawtooth / constant)
// substituting deserialised samples at the acquisition core's sample mux.
module fmc_adc_pattern_gen #(
    parameter int g_NB_CHANNELS = 4,
    parameter int g_DATA_WIDTH  = 16
) (
    input  logic                  clk_sys,
    input  logic                  sys_rst_n,
    fmc_adc_pattern_gen_if.slave  bus
);
    localparam int N  = g_NB_CHANNELS;
    localparam int W  = g_DATA_WIDTH;
    // Two guard bits: a full-range unsigned step added to a signed sample cannot overflow.
    localparam int XW = W + 2;

    localparam logic [1:0] MODE_ZERO     = 2'd0;
    localparam logic [1:0] MODE_TRIANGLE = 2'd1;
    localparam logic [1:0] MODE_SAWTOOTH = 2'd2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERR} state_t;

    state_t               state_reg;
    logic [1:0]           mode_reg;
    logic [W-1:0]         step_reg;
    logic signed [W-1:0]  lower_reg;
    logic signed [W-1:0]  upper_reg;
    logic [N-1:0]         invert_reg;
    logic signed [W-1:0]  cur_reg;
    logic                 dir_reg;
    logic [N*W-1:0]       data_reg;
    logic                 valid_reg;
    logic                 running_reg;
    logic                 cfg_err_reg;
    logic [31:0]          cnt_reg;

    logic signed [W-1:0]  base_cur;
    logic                 base_dir;
    logic signed [XW-1:0] sum_up;
    logic signed [XW-1:0] sum_dn;
    logic signed [XW-1:0] lower_x;
    logic signed [XW-1:0] upper_x;
    logic signed [W-1:0]  cur_next;
    logic                 dir_next;
    logic signed [W-1:0]  neg_sat;
    logic [N*W-1:0]       data_next;
    logic signed [W-1:0]  cfg_lower;
    logic signed [W-1:0]  cfg_upper;

    assign cfg_lower = bus.lower;
    assign cfg_upper = bus.upper;

    // A sync restarts the waveform before any coincident sample is taken.
    always_comb begin
        base_cur = bus.sync ? lower_reg : cur_reg;
        base_dir = bus.sync ? DIR_UP : dir_reg;
        lower_x  = XW'(lower_reg);
        upper_x  = XW'(upper_reg);
        sum_up   = XW'(base_cur) + XW'(step_reg);
        sum_dn   = XW'(base_cur) - XW'(step_reg);
        cur_next = base_cur;
        dir_next = base_dir;
        case (mode_reg)
            MODE_TRIANGLE: begin
                if (base_dir == DIR_UP) begin
                    if (sum_up >= upper_x) begin
                        cur_next = upper_reg;
                        dir_next = DIR_DOWN;
                    end else begin
                        cur_next = sum_up[W-1:0];
                    end
                end else begin
                    if (sum_dn <= lower_x) begin
                        cur_next = lower_reg;
                        dir_next = DIR_UP;
                    end else begin
                        cur_next = sum_dn[W-1:0];
                    end
                end
            end
            MODE_SAWTOOTH: begin
                cur_next = (sum_up > upper_x) ? lower_reg : sum_up[W-1:0];
                dir_next = DIR_UP;
            end
            default: begin
                cur_next = lower_reg;
                dir_next = DIR_UP;
            end
        endcase
    end

    // Negating the most negative code saturates to the most positive one.
    always_comb begin
        if (base_cur == {1'b1, {(W-1){1'b0}}})
            neg_sat = {1'b0, {(W-1){1'b1}}};
        else
            neg_sat = -base_cur;
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign data_next[gi*W +: W] = (mode_reg == MODE_ZERO) ? '0 :
                                          invert_reg[gi] ? neg_sat : base_cur;
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (!sys_rst_n) begin
            state_reg   <= ST_IDLE;
            mode_reg    <= MODE_ZERO;
            step_reg    <= '0;
            lower_reg   <= '0;
            upper_reg   <= '0;
            invert_reg  <= '0;
            cur_reg     <= '0;
            dir_reg     <= DIR_UP;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            running_reg <= 1'b0;
            cfg_err_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.enable) begin
                        mode_reg   <= bus.mode;
                        step_reg   <= bus.step;
                        lower_reg  <= cfg_lower;
                        upper_reg  <= cfg_upper;
                        invert_reg <= bus.invert;
                        if (cfg_lower > cfg_upper) begin
                            state_reg   <= ST_ERR;
                            cfg_err_reg <= 1'b1;
                        end else begin
                            state_reg   <= ST_RUN;
                            running_reg <= 1'b1;
                            cur_reg     <= cfg_lower;
                            dir_reg     <= DIR_UP;
                            cnt_reg     <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (!bus.enable) begin
                        state_reg   <= ST_IDLE;
                        running_reg <= 1'b0;
                    end else if (bus.sample_en) begin
                        valid_reg <= 1'b1;
                        data_reg  <= data_next;
                        cur_reg   <= cur_next;
                        dir_reg   <= dir_next;
                        cnt_reg   <= bus.sync ? 32'd1 : cnt_reg + 32'd1;
                    end else if (bus.sync) begin
                        cur_reg <= lower_reg;
                        dir_reg <= DIR_UP;
                        cnt_reg <= '0;
                    end
                end
                ST_ERR: begin
                    if (!bus.enable) begin
                        state_reg   <= ST_IDLE;
                        cfg_err_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.data       = data_reg;
    assign bus.valid      = valid_reg;
    assign bus.running    = running_reg;
    assign bus.cfg_err    = cfg_err_reg;
    assign bus.sample_cnt = cnt_reg;
endmodule

// File: tb/tb_fmc_adc_pattern_gen.sv
// Directed bench for fmc_adc_pattern_gen: triangle, sawtooth, constant/invert,
// zero, config error, sync, enable-drop and reset-in-run scenarios.
module tb_fmc_adc_pattern_gen;
    localparam int N = 4;
    localparam int W = 16;

    logic clk_sys   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   tests     = 0;
    int   fails     = 0;

    fmc_adc_pattern_gen_if #(.g_NB_CHANNELS(N), .g_DATA_WIDTH(W)) bus ();

    fmc_adc_pattern_gen #(.g_NB_CHANNELS(N), .g_DATA_WIDTH(W)) dut (
        .clk_sys   (clk_sys),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rep4(input int v);
        logic [15:0] s;
        s = 16'(v);
        return {s, s, s, s};
    endfunction

    // Strobe for one cycle; outputs of that sample are visible on return.
    task automatic strobe();
        bus.sample_en = 1'b1;
        tick();
        bus.sample_en = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic start(input logic [1:0] m, input int stp, input int lo, input int hi,
                         input logic [3:0] inv);
        bus.mode   = m;
        bus.step   = 16'(stp);
        bus.lower  = 16'(lo);
        bus.upper  = 16'(hi);
        bus.invert = inv;
        bus.enable = 1'b1;
        tick();
    endtask

    task automatic stop();
        bus.enable = 1'b0;
        tick();
    endtask

    int valid_seen;

    initial begin
        bus.enable = 0; bus.sync = 0; bus.sample_en = 0; bus.mode = 0;
        bus.step = 0; bus.lower = 0; bus.upper = 0; bus.invert = 0;
        gap(3);
        check("rst_data", bus.data, 64'd0);
        check("rst_valid", 64'(bus.valid), 64'd0);
        check("rst_running", 64'(bus.running), 64'd0);
        check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
        check("rst_cnt", 64'(bus.sample_cnt), 64'd0);
        sys_rst_n = 1'b1;
        tick();

        // Triangle -400..400 step 8, strobe every 8 cycles
        start(2'd1, 8, -400, 400, 4'b0000);
        check("tri_running", 64'(bus.running), 64'd1);
        bus.step = 16'd3;
        bus.upper = 16'd0;
        for (int i = 0; i <= 200; i++) begin
            strobe();
            if (i == 0) check("tri_s0", bus.data, rep4(-400));
            if (i == 1) check("tri_s1", bus.data, rep4(-392));
            if (i == 2) check("tri_s2", bus.data, rep4(-384));
            if (i == 3) check("tri_s3", bus.data, rep4(-376));
            if (i == 100) check("tri_s100", bus.data, rep4(400));
            if (i == 101) check("tri_s101", bus.data, rep4(392));
            if (i == 200) check("tri_s200", bus.data, rep4(-400));
            if (i == 0) check("tri_valid", 64'(bus.valid), 64'd1);
            tick();
            if (i == 0) check("tri_valid_1cyc", 64'(bus.valid), 64'd0);
            gap(6);
        end
        check("tri_cnt", 64'(bus.sample_cnt), 64'd201);
        stop();
        check("tri_stop_running", 64'(bus.running), 64'd0);
        check("tri_hold_data", bus.data, rep4(-400));

        // Sawtooth 0..10 step 4
        start(2'd2, 4, 0, 10, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            strobe();
            check($sformatf("saw_s%0d", i), bus.data, rep4((i % 3) * 4));
            gap(2);
        end
        check("saw_cnt", 64'(bus.sample_cnt), 64'd6);
        stop();

        // Constant at most-negative code, channels 0 and 2 inverted
        start(2'd3, 8, -32768, 100, 4'b0101);
        strobe();
        check("const_s0", bus.data, 64'h8000_7FFF_8000_7FFF);
        gap(2);
        strobe();
        check("const_s1", bus.data, 64'h8000_7FFF_8000_7FFF);
        stop();

        // Zero mode, inversion must not apply
        start(2'd0, 8, 5, 100, 4'b0101);
        strobe();
        check("zero_data", bus.data, 64'd0);
        check("zero_valid", 64'(bus.valid), 64'd1);
        stop();

        // Configuration error
        start(2'd1, 8, 5, -5, 4'b0000);
        check("err_cfg_err", 64'(bus.cfg_err), 64'd1);
        check("err_running", 64'(bus.running), 64'd0);
        valid_seen = 0;
        for (int i = 0; i < 100; i++) begin
            strobe();
            if (bus.valid) valid_seen++;
            tick();
        end
        check("err_no_valid", 64'(valid_seen), 64'd0);
        stop();
        check("err_cleared", 64'(bus.cfg_err), 64'd0);

        // Sync coincident with a strobe after 7 samples
        start(2'd1, 8, -400, 400, 4'b0000);
        for (int i = 0; i < 7; i++) begin
            strobe();
            tick();
        end
        check("sync_pre", bus.data, rep4(-352));
        bus.sync = 1'b1;
        strobe();
        bus.sync = 1'b0;
        check("sync_data", bus.data, rep4(-400));
        check("sync_cnt", 64'(bus.sample_cnt), 64'd1);
        tick();
        strobe();
        check("sync_next", bus.data, rep4(-392));
        check("sync_cnt2", 64'(bus.sample_cnt), 64'd2);

        // Enable drop coincident with a strobe: no sample produced
        bus.enable = 1'b0;
        strobe();
        check("endrop_valid", 64'(bus.valid), 64'd0);
        check("endrop_running", 64'(bus.running), 64'd0);
        check("endrop_cnt", 64'(bus.sample_cnt), 64'd2);

        // Reset during RUN coincident with a strobe
        start(2'd1, 8, -400, 400, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            strobe();
            tick();
        end
        sys_rst_n = 1'b0;
        strobe();
        sys_rst_n = 1'b1;
        check("rstrun_valid", 64'(bus.valid), 64'd0);
        check("rstrun_data", bus.data, 64'd0);
        check("rstrun_cnt", 64'(bus.sample_cnt), 64'd0);
        check("rstrun_running", 64'(bus.running), 64'd0);
        tick();
        check("restart_running", 64'(bus.running), 64'd1);
        strobe();
        check("restart_data", bus.data, rep4(-400));
        check("restart_cnt", 64'(bus.sample_cnt), 64'd1);
        stop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
